// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared widths, op codes and FSM encoding for alu_seq
//
// Purpose : Common definitions imported by alu_seq and its integrators.
// Contents: DATA_W/OP_W/CNT_W widths, ALU select codes (OP_LOAD is handled
//           inside alu_seq, the others are decoded by the external ALU),
//           and the sequencer state encoding.
package alu_seq_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 5;
    localparam int CNT_W  = 3;

    localparam logic [OP_W-1:0] OP_AND  = 5'b00100;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00101;
    localparam logic [OP_W-1:0] OP_XOR  = 5'b00110;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b01000;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b10000;
    localparam logic [OP_W-1:0] OP_LOAD = 5'b11111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - accumulator sequencer driving an external combinational ALU
//
// Purpose : Accepts one command in IDLE, then applies the selected ALU op to
//           the accumulator cnt+1 times (EXEC), then pulses done (DONE).
// Ports   : clk, rst (async, active high)
//           cmd_valid/cmd_ready handshake with cmd_op, cmd_cin, cmd_data, cmd_cnt
//           alu_s/alu_cin/alu_a/alu_b -> external ALU, alu_y <- ALU result
//           acc, zero, busy, done status outputs
module alu_seq
    import alu_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic              cmd_cin,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [CNT_W-1:0]  cmd_cnt,
    output logic [OP_W-1:0]   alu_s,
    output logic              alu_cin,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_y,
    output logic [DATA_W-1:0] acc,
    output logic              zero,
    output logic              busy,
    output logic              done
);

    state_t             r_state;
    logic [DATA_W-1:0]  r_acc;
    logic [OP_W-1:0]    r_alu_s;
    logic               r_alu_cin;
    logic [DATA_W-1:0]  r_alu_b;
    logic [CNT_W-1:0]   r_remaining;
    logic               r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_alu_s     <= '0;
            r_alu_cin   <= 1'b0;
            r_alu_b     <= '0;
            r_remaining <= '0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (cmd_valid) begin
                        r_alu_s     <= cmd_op;
                        r_alu_cin   <= cmd_cin;
                        r_alu_b     <= cmd_data;
                        r_remaining <= cmd_cnt;
                        r_state     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // LOAD bypasses the ALU so it works with any ALU decode
                    r_acc <= (r_alu_s == OP_LOAD) ? r_alu_b : alu_y;
                    // Exit on zero so the counter never wraps
                    if (r_remaining == '0) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_remaining <= r_remaining - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Gated by rst so nothing is offered while reset is held
    assign cmd_ready = (r_state == ST_IDLE) && !rst;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign acc       = r_acc;
    assign zero      = (r_acc == '0);
    assign alu_a     = r_acc;
    assign alu_b     = r_alu_b;
    assign alu_s     = r_alu_s;
    assign alu_cin   = r_alu_cin;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed scoreboard bench for alu_seq with a behavioural ALU
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op = '0;
    logic              cmd_cin = 1'b0;
    logic [DATA_W-1:0] cmd_data = '0;
    logic [CNT_W-1:0]  cmd_cnt = '0;
    logic [OP_W-1:0]   alu_s;
    logic              alu_cin;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_y;
    logic [DATA_W-1:0] acc;
    logic              zero;
    logic              busy;
    logic              done;

    int n_tests = 0;
    int n_fail  = 0;
    int done_seen = 0;
    logic [DATA_W-1:0] sb[$];

    always #5 clk = ~clk;

    alu_seq dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_cin(cmd_cin), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt),
        .alu_s(alu_s), .alu_cin(alu_cin), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
        .acc(acc), .zero(zero), .busy(busy), .done(done)
    );

    // Downstream ALU as an integrator would place it beside alu_seq
    always_comb begin
        alu_y = '0;
        case (alu_s)
            OP_AND:  alu_y = alu_a & alu_b;
            OP_OR:   alu_y = alu_a | alu_b;
            OP_XOR:  alu_y = alu_a ^ alu_b;
            OP_SHL:  alu_y = {alu_a[6:0], alu_cin};
            OP_SHR:  alu_y = {alu_cin, alu_a[7:1]};
            default: alu_y = alu_a + alu_b + {7'd0, alu_cin};
        endcase
    end

    always @(posedge clk) if (done === 1'b1) done_seen++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns after the accepting edge E0, with inputs already released
    task automatic send_cmd(input logic [OP_W-1:0] op, input logic cin,
                            input logic [DATA_W-1:0] data, input logic [CNT_W-1:0] cnt,
                            output int waited);
        cmd_op = op; cmd_cin = cin; cmd_data = data; cmd_cnt = cnt;
        cmd_valid = 1'b1;
        waited = 0;
        while (cmd_ready !== 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (done !== 1'b1 && cycles < 40);
    endtask

    // Waits for completion, checks latency and acc against the scoreboard,
    // then checks the return to IDLE one cycle later
    task automatic finish_cmd(input string tag, input int cnt);
        int c;
        logic [DATA_W-1:0] exp;
        wait_done(c);
        check({tag, "_latency"}, c, cnt + 1);
        exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        check({tag, "_acc"}, acc, exp);
        tick();
        check({tag, "_done_drop"}, done, 1'b0);
        check({tag, "_ready"}, cmd_ready, 1'b1);
    endtask

    initial begin
        int w;
        int snap;

        // Reset
        repeat (2) tick();
        check("rst_ready_low", cmd_ready, 1'b0);
        check("rst_acc", acc, 8'h00);
        #1 rst = 1'b0;
        #1;
        check("rel_ready", cmd_ready, 1'b1);
        check("rel_acc", acc, 8'h00);
        check("rel_zero", zero, 1'b1);
        check("rel_busy", busy, 1'b0);
        check("rel_done", done, 1'b0);

        // LOAD / logic ops
        sb.push_back(8'hF0); send_cmd(OP_LOAD, 1'b0, 8'hF0, 3'd0, w);
        check("load_busy", busy, 1'b1);
        finish_cmd("load_f0", 0);
        sb.push_back(8'hF0); send_cmd(OP_AND, 1'b0, 8'hFF, 3'd0, w); finish_cmd("and_ff", 0);
        sb.push_back(8'hF0); send_cmd(OP_OR,  1'b0, 8'h00, 3'd0, w); finish_cmd("or_00", 0);
        sb.push_back(8'hFF); send_cmd(OP_XOR, 1'b0, 8'h0F, 3'd0, w); finish_cmd("xor_0f", 0);
        check("xor_zero", zero, 1'b0);

        // SHL cnt 2, per-iteration accumulator
        sb.push_back(8'h18); send_cmd(OP_LOAD, 1'b0, 8'h18, 3'd0, w); finish_cmd("load_18", 0);
        sb.push_back(8'h30); sb.push_back(8'h60); sb.push_back(8'hC0);
        send_cmd(OP_SHL, 1'b0, 8'h00, 3'd2, w);
        check("shl_busy0", busy, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("shl_step_acc", acc, sb.pop_front());
            check("shl_step_done", done, (i == 2) ? 1'b1 : 1'b0);
            check("shl_step_busy", busy, 1'b1);
        end
        tick();
        check("shl_busy_end", busy, 1'b0);

        // SHR cnt 7 down to zero, single done pulse
        snap = done_seen;
        sb.push_back(8'h00); send_cmd(OP_SHR, 1'b0, 8'h00, 3'd7, w); finish_cmd("shr_c0", 7);
        check("shr_zero", zero, 1'b1);
        repeat (3) tick();
        check("shr_pulses", done_seen - snap, 1);

        // Command held valid during EXEC: accepted once, only from IDLE
        sb.push_back(8'h55); sb.push_back(8'hAA);
        send_cmd(OP_LOAD, 1'b0, 8'h55, 3'd3, w);
        snap = done_seen;
        send_cmd(OP_XOR, 1'b0, 8'hFF, 3'd0, w);
        check("hold_wait", w, 5);
        check("hold_first", acc, sb.pop_front());
        finish_cmd("hold_xor", 0);
        repeat (4) tick();
        check("hold_pulses", done_seen - snap, 2);
        check("hold_no_dup", acc, 8'hAA);

        // Reset mid SHL cnt 7
        sb.push_back(8'h01); send_cmd(OP_LOAD, 1'b0, 8'h01, 3'd0, w); finish_cmd("load_01", 0);
        send_cmd(OP_SHL, 1'b0, 8'h00, 3'd7, w);
        repeat (3) tick();
        check("mid_acc_e3", acc, 8'h08);
        snap = done_seen;
        rst = 1'b1;
        #1;
        check("mid_rst_acc", acc, 8'h00);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", cmd_ready, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        check("mid_rel_ready", cmd_ready, 1'b1);
        repeat (10) tick();
        check("mid_no_done", done_seen - snap, 0);
        sb.push_back(8'h3C); send_cmd(OP_LOAD, 1'b0, 8'h3C, 3'd1, w); finish_cmd("post_rst", 1);
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have one clock and one asynchronous, active-high reset: clock `clk`, reset `rst`.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port: cmd_valid  input  1  command present; master holds it and all cmd_* stable until accepted.
REQ-005 SHALL have port: cmd_ready  output  1  block can accept a command.
REQ-006 SHALL have port: cmd_op  input  5  ALU select code, or LOAD (5'b11111).
REQ-007 SHALL have port: cmd_cin  input  1  carry-in for the operation.
REQ-008 SHALL have port: cmd_data  input  8  B operand; the load value for LOAD.
REQ-009 SHALL have port: cmd_cnt  input  3  repeat count; n gives n+1 iterations (1..8).
REQ-010 SHALL have port: alu_s  output  5  registered op to the downstream ALU select.
REQ-011 SHALL have port: alu_cin  output  1  registered carry-in to the ALU.
REQ-012 SHALL have port: alu_a  output  8  current accumulator value, driven to ALU A.
REQ-013 SHALL have port: alu_b  output  8  registered operand, driven to ALU B.
REQ-014 SHALL have port: alu_y  input  8  ALU result, combinational from alu_s/alu_cin/alu_a/alu_b.
REQ-015 SHALL have port: acc  output  8  accumulator.
REQ-016 SHALL have port: zero  output  1  high when acc == 8'h00 (combinational from acc).
REQ-017 SHALL have port: busy  output  1  high in EXEC and DONE.
REQ-018 SHALL have port: done  output  1  one-cycle completion pulse.

Function
REQ-019 SHALL implement the FSM states IDLE, EXEC and DONE.
REQ-020 IDLE: cmd_ready=1; on cmd_valid&cmd_ready at edge E0, SHALL latch cmd_op→alu_s, cmd_cin→alu_cin, cmd_data→alu_b, cmd_cnt→remaining counter, and go to EXEC.
REQ-021 EXEC: at each edge SHALL write acc←alu_y, or acc←alu_b when alu_s==LOAD.
REQ-022 EXEC: if remaining==0, SHALL go to DONE; otherwise SHALL decrement remaining and stay in EXEC.
REQ-023 Command with count n: acc updates at edges E1..E(n+1); state DONE and the final acc SHALL appear together after E(n+1).
REQ-024 DONE: done=1, cmd_ready=0 for exactly one cycle, then SHALL return to IDLE; no back-to-back acceptance, so minimum command spacing is n+3 cycles.
REQ-025 cmd_valid in EXEC/DONE SHALL be ignored (not latched, not lost); acceptance SHALL occur only in IDLE.
REQ-026 alu_s, alu_cin and alu_b SHALL hold their last command values in IDLE.
REQ-027 acc SHALL hold its value outside EXEC.
REQ-028 LOAD SHALL honour cmd_cnt by reloading the same value on each iteration.
REQ-029 All arithmetic is 8-bit; the ALU carry-out is not observed; wrap is the ALU's responsibility.
REQ-030 remaining counter is 3 bits; it SHALL never underflow because the exit is taken at 0.

Reset
REQ-031 rst asserted SHALL immediately (asynchronously) set: state=IDLE, acc=8'h00, alu_s=5'b00000, alu_cin=0, alu_b=8'h00, remaining=0, done=0.
REQ-032 cmd_ready SHALL be forced to 0 while rst=1 and SHALL be 1 in the first cycle after release.
REQ-033 Reset during EXEC/DONE SHALL abort the command: no done pulse, and partial acc is discarded.

Structure
REQ-034 Package alu_seq_pkg SHALL hold: data width 8, op width 5, count width 3; op constants OP_AND=5'b00100, OP_OR=5'b00101, OP_XOR=5'b00110, OP_SHL=5'b01000, OP_SHR=5'b10000, OP_LOAD=5'b11111; FSM state encoding.
REQ-035 No sub-module SHALL be used; the ALU SHALL be instantiated beside alu_seq by the integrator and connected alu_a/alu_b/alu_s/alu_cin→A/B/S/Cin, Y→alu_y.
REQ-036 Estimated RTL size is 150–250 lines.

Verification (bench instantiates alu_seq plus the ALU)
REQ-037 Reset: rst pulse → acc=00, zero=1, busy=0, done=0, cmd_ready=1 one cycle after release.
REQ-038 LOAD 8'hF0 cnt 0 → acc=F0 and done=1 in the cycle after E1; then AND 8'hFF → F0; OR 8'h00 → F0; XOR 8'h0F → FF.
REQ-039 LOAD 8'h18, then SHL cnt 2 → acc 30, 60, C0 at E1..E3; done high after E3 only; busy high for 4 cycles.
REQ-040 From acc=C0, SHR cnt 7 → 8 iterations → acc=00, zero=1, single done pulse.
REQ-041 Second command with cmd_valid held high during EXEC → not accepted until IDLE; accepted exactly once; no duplicate execution.
REQ-042 rst asserted mid-way through SHL cnt 7 (after E3) → acc=00 asynchronously, no done, next command executes normally.
